psram_arbiter: RTL and testbench

//  N-channel PSRAM request arbiter in the clk64 domain, between the synchronised client strobes and the PSRAM controller.

---
 rtl/psram_arbiter_if.sv | 34 +++
 rtl/psram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_psram_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_arbiter_if.sv
// Client/controller bus for the PSRAM arbiter: per-channel request strobes,
// status pulses and the single controller-side strobe/busy handshake.
interface psram_arbiter_if #(
    parameter int NCH = 3,
    parameter int AW  = 22,
    parameter int DW  = 16
);
    logic [NCH-1:0]    ch_read;
    logic [NCH-1:0]    ch_write;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_din;
    logic [NCH-1:0]    ch_busy;
    logic [NCH-1:0]    ch_done;
    logic [NCH-1:0]    ch_err;
    logic [DW-1:0]     ch_dout;
    logic              mem_read;
    logic              mem_write;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_din;
    logic [DW-1:0]     mem_dout;
    logic              mem_busy;

    // arbiter side
    modport slave (
        input  ch_read, ch_write, ch_addr, ch_din, mem_dout, mem_busy,
        output ch_busy, ch_done, ch_err, ch_dout, mem_read, mem_write, mem_addr, mem_din
    );

    // clients + controller side
    modport master (
        output ch_read, ch_write, ch_addr, ch_din, mem_dout, mem_busy,
        input  ch_busy, ch_done, ch_err, ch_dout, mem_read, mem_write, mem_addr, mem_din
    );
endinterface

// File: rtl/psram_arbiter.sv
// N-channel PSRAM request arbiter: one latched request slot per channel, a single
// grant FSM driving the controller strobe, with a watchdog on busy never rising.
module psram_arbiter_slot #(
    parameter int AW = 22,
    parameter int DW = 16
) (
    input  logic          clk64,
    input  logic          resetn,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic          clr,
    output logic          busy,
    output logic          op_rd,
    output logic [AW-1:0] addr_q,
    output logic [DW-1:0] din_q
);
    // clr only arrives while busy, so it can never collide with a capture
    always_ff @(posedge clk64 or negedge resetn) begin
        if (!resetn) begin
            busy   <= 1'b0;
            op_rd  <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else if (!busy && (rd || wr)) begin
            busy   <= 1'b1;
            op_rd  <= rd;
            addr_q <= addr;
            din_q  <= din;
        end else if (clr) begin
            busy   <= 1'b0;
        end
    end
endmodule

module psram_arbiter #(
    parameter int NCH     = 3,
    parameter int AW      = 22,
    parameter int DW      = 16,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 15
) (
    input  logic           clk64,
    input  logic           resetn,
    psram_arbiter_if.slave bus
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WBUSY = 2'd2;
    localparam logic [1:0] S_WDONE = 2'd3;

    logic [1:0]                 state;
    logic [GW-1:0]              gnt;
    logic [GW-1:0]              rr_ptr;
    logic [7:0]                 wd;
    logic                       op_rd;

    logic [NCH-1:0]             slot_busy;
    logic [NCH-1:0]             slot_rd;
    logic [NCH-1:0][AW-1:0]     slot_addr;
    logic [NCH-1:0][DW-1:0]     slot_din;
    logic [NCH-1:0]             gnt_oh;
    logic [NCH-1:0]             slot_clr;

    logic [GW-1:0]              pick;
    logic                       pick_ok;
    logic                       wd_hit;
    logic                       fin_ok;
    logic                       fin;

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_ch
            assign gnt_oh[i]   = (gnt == GW'(i));
            assign slot_clr[i] = gnt_oh[i] & fin;

            psram_arbiter_slot #(.AW(AW), .DW(DW)) u_slot (
                .clk64  (clk64),
                .resetn (resetn),
                .rd     (bus.ch_read[i]),
                .wr     (bus.ch_write[i]),
                .addr   (bus.ch_addr[i*AW +: AW]),
                .din    (bus.ch_din[i*DW +: DW]),
                .clr    (slot_clr[i]),
                .busy   (slot_busy[i]),
                .op_rd  (slot_rd[i]),
                .addr_q (slot_addr[i]),
                .din_q  (slot_din[i])
            );
        end
    endgenerate

    assign bus.ch_busy = slot_busy;

    // Scan from the highest search offset down so the lowest offset wins last.
    // Only consulted in IDLE, where every busy slot is still waiting.
    always_comb begin
        int idx;
        idx     = 0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = (RR_MODE != 0) ? ((int'(rr_ptr) + k) % NCH) : k;
            if (slot_busy[idx]) begin
                pick    = GW'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    assign wd_hit = (state == S_WBUSY) && !bus.mem_busy && (wd == WD_LAST);
    assign fin_ok = (state == S_WDONE) && !bus.mem_busy;
    assign fin    = wd_hit || fin_ok;

    always_ff @(posedge clk64 or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            gnt           <= '0;
            rr_ptr        <= '0;
            wd            <= '0;
            op_rd         <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_din   <= '0;
            bus.ch_done   <= '0;
            bus.ch_err    <= '0;
            bus.ch_dout   <= '0;
        end else begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.ch_done   <= '0;
            bus.ch_err    <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_ok) begin
                        gnt          <= pick;
                        rr_ptr       <= (pick == GW'(NCH - 1)) ? '0 : pick + 1'b1;
                        op_rd        <= slot_rd[pick];
                        bus.mem_addr <= slot_addr[pick];
                        bus.mem_din  <= slot_din[pick];
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    bus.mem_read  <= op_rd;
                    bus.mem_write <= !op_rd;
                    wd            <= '0;
                    state         <= S_WBUSY;
                end
                S_WBUSY: begin
                    // busy left high from earlier is taken as the acknowledge
                    if (bus.mem_busy) begin
                        state <= S_WDONE;
                    end else if (wd_hit) begin
                        bus.ch_done <= gnt_oh;
                        bus.ch_err  <= gnt_oh;
                        state       <= S_IDLE;
                    end else begin
                        wd <= wd + 8'd1;
                    end
                end
                S_WDONE: begin
                    if (fin_ok) begin
                        if (op_rd)
                            bus.ch_dout <= bus.mem_dout;
                        bus.ch_done <= gnt_oh;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psram_arbiter.sv
// Randomised bench for psram_arbiter: a request-level model predicts grants,
// strobes and completions; a negedge monitor checks everything against it.
module tb_psram_arbiter;
    localparam int NCH = 3;
    localparam int AW  = 22;
    localparam int DW  = 16;
    localparam int RR  = 1;
    localparam int TO  = 15;

    typedef struct {
        int            ch;
        bit            err;
        bit            rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk64 = 1'b0;
    logic resetn = 1'b0;
    always #5 clk64 = ~clk64;

    psram_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

    psram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RR_MODE(RR), .TIMEOUT(TO)) dut (
        .clk64  (clk64),
        .resetn (resetn),
        .bus    (bus)
    );

    int cyc = 0;
    always @(posedge clk64) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // model state (monitor-owned)
    bit            p_valid [NCH];
    int            p_cap   [NCH];
    bit            p_rd    [NCH];
    logic [AW-1:0] p_addr  [NCH];
    logic [DW-1:0] p_din   [NCH];
    exp_t          exp_q[$];
    int            rr_ptr = 0;
    int            last_done = 0;
    logic [DW-1:0] exp_dout = '0;
    int            plan_rise = 0;
    int            plan_fall = 0;
    logic [DW-1:0] plan_dout = '0;
    int            hang_seen = 0;

    // stimulus-owned
    bit no_to = 1'b0;
    int hang_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, want);
        end
    endtask

    // controller model: follows the plan the monitor draws up at each strobe
    initial begin
        bus.mem_busy = 1'b0;
        bus.mem_dout = '0;
        forever begin
            @(posedge clk64);
            #1;
            if (!resetn) begin
                bus.mem_busy = 1'b0;
                bus.mem_dout = '0;
            end else begin
                bus.mem_busy = (cyc >= plan_rise) && (cyc < plan_fall);
                bus.mem_dout = (cyc >= plan_fall) ? plan_dout : DW'($urandom);
            end
        end
    end

    logic [NCH-1:0] e_done, e_err, e_busy;
    exp_t h;
    bit   obs_s, exp_s, any_p;
    int   min_cap, gs, idx, d1, d2;

    always @(negedge clk64) begin
        if (!resetn) begin
            chk("reset_outputs", 64'({bus.ch_busy, bus.ch_done, bus.ch_err, bus.ch_dout,
                                      bus.mem_read, bus.mem_write, bus.mem_addr != '0, bus.mem_din}), 64'd0);
            for (int i = 0; i < NCH; i++) p_valid[i] = 1'b0;
            exp_q.delete();
            rr_ptr    = 0;
            exp_dout  = '0;
            plan_rise = 0;
            plan_fall = 0;
            last_done = cyc;
        end else begin
            if (hang_cnt != hang_seen) begin
                chk("wait_bound", 64'(hang_cnt), 64'(hang_seen));
                hang_seen = hang_cnt;
            end
            // held address/data while a request is outstanding
            if (exp_q.size() > 0)
                chk("mem_hold", 64'({bus.mem_addr, bus.mem_din}), 64'({exp_q[0].addr, exp_q[0].din}));

            e_done = '0;
            e_err  = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e_done[exp_q[0].ch] = 1'b1;
                e_err[exp_q[0].ch]  = exp_q[0].err;
            end
            if (e_done != '0 || bus.ch_done != '0) chk("ch_done", 64'(bus.ch_done), 64'(e_done));
            if (e_err != '0 || bus.ch_err != '0)   chk("ch_err", 64'(bus.ch_err), 64'(e_err));
            if (e_done != '0) begin
                h = exp_q.pop_front();
                if (h.rd && !h.err) exp_dout = h.data;
                chk("ch_dout", 64'(bus.ch_dout), 64'(exp_dout));
                p_valid[h.ch] = 1'b0;
                last_done = cyc;
            end

            e_busy = '0;
            for (int i = 0; i < NCH; i++) e_busy[i] = p_valid[i];
            if (e_busy != '0 || bus.ch_busy != '0) chk("ch_busy", 64'(bus.ch_busy), 64'(e_busy));

            // strobe timing: grant in the first idle cycle with a pending slot, strobe two later
            any_p = 1'b0;
            min_cap = 32'h7fffffff;
            for (int i = 0; i < NCH; i++)
                if (p_valid[i]) begin
                    any_p = 1'b1;
                    if (p_cap[i] < min_cap) min_cap = p_cap[i];
                end
            exp_s = (exp_q.size() == 0) && any_p &&
                    (cyc == (((min_cap + 1) > last_done) ? (min_cap + 1) : last_done) + 2);
            obs_s = bus.mem_read || bus.mem_write;
            if (obs_s) chk("rw_excl", 64'(bus.mem_read & bus.mem_write), 64'd0);
            if (obs_s || exp_s) chk("strobe", 64'(obs_s), 64'(exp_s));
            if (obs_s && exp_s) begin
                gs = -1;
                for (int k = 0; k < NCH; k++) begin
                    idx = (RR != 0) ? (rr_ptr + k) % NCH : k;
                    if (gs < 0 && p_valid[idx] && p_cap[idx] <= cyc - 3) gs = idx;
                end
                if (gs >= 0) begin
                    chk("mem_op", 64'({bus.mem_read, bus.mem_write}), p_rd[gs] ? 64'd2 : 64'd1);
                    chk("mem_addr", 64'(bus.mem_addr), 64'(p_addr[gs]));
                    chk("mem_din", 64'(bus.mem_din), 64'(p_din[gs]));
                    rr_ptr = (gs + 1) % NCH;
                    h.ch = gs; h.rd = p_rd[gs]; h.addr = p_addr[gs]; h.din = p_din[gs];
                    if (!no_to && $urandom_range(0, 7) == 0) begin
                        plan_rise = 0;
                        plan_fall = 0;
                        h.err = 1'b1; h.data = '0; h.due = cyc + TO;
                    end else begin
                        d1 = $urandom_range(1, 4);
                        d2 = no_to ? 8 : $urandom_range(1, 5);
                        plan_rise = cyc + d1;
                        plan_fall = plan_rise + d2;
                        plan_dout = DW'($urandom);
                        h.err = 1'b0; h.data = plan_dout; h.due = plan_fall + 1;
                    end
                    exp_q.push_back(h);
                end
            end

            // capture: idle channels take the strobe, read beats write
            for (int i = 0; i < NCH; i++)
                if ((bus.ch_read[i] || bus.ch_write[i]) && !p_valid[i]) begin
                    p_valid[i] = 1'b1;
                    p_cap[i]   = cyc;
                    p_rd[i]    = bus.ch_read[i];
                    p_addr[i]  = bus.ch_addr[i*AW +: AW];
                    p_din[i]   = bus.ch_din[i*DW +: DW];
                end
        end
    end

    task automatic drive(input logic [NCH-1:0] rd, input logic [NCH-1:0] wr);
        @(posedge clk64);
        #2;
        bus.ch_read  = rd;
        bus.ch_write = wr;
        for (int i = 0; i < NCH; i++) begin
            bus.ch_addr[i*AW +: AW] = AW'($urandom);
            bus.ch_din[i*DW +: DW]  = DW'($urandom);
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 400 && !idle; t++) begin
            @(posedge clk64);
            idle = (exp_q.size() == 0) && !p_valid[0] && !p_valid[1] && !p_valid[2];
        end
        if (!idle) hang_cnt++;
    endtask

    task automatic rand_cycles(input int n);
        logic [NCH-1:0] rd, wr;
        int r;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NCH; i++) begin
                r = $urandom_range(0, 9);
                rd[i] = (r == 0) || (r == 1);
                wr[i] = (r == 1) || (r == 2);
            end
            drive(rd, wr);
        end
        drive('0, '0);
    endtask

    initial begin
        bit seen;
        bus.ch_read  = '0;
        bus.ch_write = '0;
        bus.ch_addr  = '0;
        bus.ch_din   = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clk64);
        #2 resetn = 1'b1;

        // all channels at once
        drive('1, '0);
        drive('0, '0);
        wait_idle();

        // write ch1 to top address, re-strobe while busy
        @(posedge clk64);
        #2;
        bus.ch_write = 3'b010;
        bus.ch_addr[1*AW +: AW] = 22'h3FFFFF;
        bus.ch_din[1*DW +: DW]  = 16'hA5A5;
        drive('0, '0);
        drive('0, 3'b010);
        drive('0, '0);
        wait_idle();

        // read and write together on ch2
        drive(3'b100, 3'b100);
        drive('0, '0);
        wait_idle();

        rand_cycles(1500);
        wait_idle();

        // reset while the controller is mid-transfer
        no_to = 1'b1;
        drive(3'b001, '0);
        drive('0, '0);
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(posedge clk64);
            #2;
            seen = bus.mem_busy;
        end
        if (!seen) hang_cnt++;
        @(posedge clk64);
        #3 resetn = 1'b0;
        repeat (2) @(posedge clk64);
        #2 resetn = 1'b1;
        no_to = 1'b0;
        repeat (20) @(posedge clk64);

        rand_cycles(400);
        wait_idle();
        repeat (4) @(posedge clk64);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
